// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and a combinational-read imem.
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  modport master (
    output imem_addr,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, branch/jump redirect, IF/ID pipeline register and
// a running count of instructions loaded into IF/ID.
module fetch_stage (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                beq,
  input  logic                bne,
  input  logic                jump,
  input  logic                zero,
  input  logic [31:0]         branch_offset,
  input  logic [25:0]         jump_index,
  input  logic [31:0]         resolve_pc4,
  fetch_stage_if.master       imem,
  output logic [31:0]         instr,
  output logic [31:0]         pc_plus4,
  output logic                valid,
  output logic                redirect,
  output logic [31:0]         fetch_count
);

  logic [31:0] pc;
  logic [31:0] pc_next_seq;
  logic        taken_branch;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] redirect_target;

  assign taken_branch = (beq & zero) | (bne & ~zero);
  assign redirect     = jump | taken_branch;

  // Shifting by two drops the top offset bits; the add wraps at 32 bits.
  assign branch_target   = resolve_pc4 + {branch_offset[29:0], 2'b00};
  assign jump_target     = {resolve_pc4[31:28], jump_index, 2'b00};
  assign redirect_target = jump ? jump_target : branch_target;

  assign pc_next_seq    = pc + 32'd4;
  assign imem.imem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= 32'd0;
      instr       <= 32'd0;
      pc_plus4    <= 32'd0;
      valid       <= 1'b0;
      fetch_count <= 32'd0;
    end else if (redirect) begin
      // Flush wins over stall: the slot behind a taken branch/jump is a nop.
      pc          <= redirect_target;
      instr       <= 32'd0;
      pc_plus4    <= 32'd0;
      valid       <= 1'b0;
    end else if (!stall) begin
      pc          <= pc_next_seq;
      instr       <= imem.imem_rdata;
      pc_plus4    <= pc_next_seq;
      valid       <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule
